// File: rtl/tile_pkg.sv
// tile_pkg: definitions shared by the tile loader and its sub-blocks.
//   - state_t       : loader FSM states
//   - DEF_*         : default element/address widths and tile edge length
package tile_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TILE_SIZE  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/rd_track_pipe.sv
// rd_track_pipe: fixed-depth shift register that follows each issued DRAM
// read so the matching SRAM write leaves exactly DEPTH cycles later.
//   clk, rst_n        : clock, asynchronous active-low reset (valid bits only)
//   in_vld/pad/addr   : element entering the pipe this cycle
//   out_vld/pad/addr  : element whose DRAM data is on the bus this cycle
//   tail_only         : no valid element except possibly the last stage,
//                       i.e. the pipe is empty from the next cycle on
module rd_track_pipe #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic                  in_pad,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_vld,
  output logic                  out_pad,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  tail_only
);

  // All stages except the output stage.
  localparam logic [DEPTH-1:0] HEAD_MASK = {DEPTH{1'b1}} >> 1;

  logic [DEPTH-1:0]      vld_p;
  logic                  pad_p  [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_p [DEPTH];

  // Stage boundary: valid bits are control and are cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Stage boundary: payload travels alongside its valid bit, no reset.
  always_ff @(posedge clk) begin
    pad_p[0]  <= in_pad;
    addr_p[0] <= in_addr;
    for (int i = 1; i < DEPTH; i++) begin
      pad_p[i]  <= pad_p[i-1];
      addr_p[i] <= addr_p[i-1];
    end
  end

  assign out_vld   = vld_p[DEPTH-1];
  assign out_pad   = pad_p[DEPTH-1];
  assign out_addr  = addr_p[DEPTH-1];
  assign tail_only = (vld_p & HEAD_MASK) == '0;

endmodule

// File: rtl/tile_loader.sv
// tile_loader: copies a TILE_SIZE x TILE_SIZE tile out of a row-major
// N x N matrix in DRAM into a dense tile in SRAM, zero-padding elements
// that fall outside the matrix. One element is issued per cycle, so the
// load time is fixed regardless of how much of the tile is padding.
//   start, src_addr, dest_addr, matrix_size, tile_row, tile_col : request
//   busy, done                        : status (done is a one-cycle pulse)
//   dram_rd_en, dram_addr, dram_rdata : fixed-latency DRAM read port
//   sram_we, sram_addr, sram_data     : SRAM write port
module tile_loader
  import tile_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int TILE_SIZE    = DEF_TILE_SIZE,
  parameter int DRAM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dest_addr,
  input  logic [ADDR_WIDTH-1:0] matrix_size,
  input  logic [ADDR_WIDTH-1:0] tile_row,
  input  logic [ADDR_WIDTH-1:0] tile_col,
  output logic                  busy,
  output logic                  done,
  output logic                  dram_rd_en,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data
);

  localparam int CNT_W = $clog2(TILE_SIZE * TILE_SIZE + 1);
  localparam int AW1   = ADDR_WIDTH + 1;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      r_cnt, c_cnt;
  logic [ADDR_WIDTH-1:0] src_q, dest_q, n_q, row_q, col_q;
  logic                  accept, issue, last_elem, in_bounds;
  logic [AW1-1:0]        row_abs, col_abs;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic                  pipe_vld, pipe_pad, pipe_tail_only;
  logic [ADDR_WIDTH-1:0] pipe_addr;

  assign accept    = (state == IDLE) && start;
  assign issue     = (state == ISSUE);
  assign last_elem = (r_cnt == CNT_W'(TILE_SIZE - 1)) &&
                     (c_cnt == CNT_W'(TILE_SIZE - 1));

  // Bounds are checked one bit wider so tile_row + r cannot wrap into range.
  assign row_abs   = {1'b0, row_q} + AW1'(r_cnt);
  assign col_abs   = {1'b0, col_q} + AW1'(c_cnt);
  assign in_bounds = (row_abs < {1'b0, n_q}) && (col_abs < {1'b0, n_q});

  // Address math is deliberately modulo 2^ADDR_WIDTH.
  assign rd_addr = src_q + row_abs[ADDR_WIDTH-1:0] * n_q + col_abs[ADDR_WIDTH-1:0];
  assign wr_addr = dest_q + ADDR_WIDTH'(r_cnt) * ADDR_WIDTH'(TILE_SIZE)
                 + ADDR_WIDTH'(c_cnt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE, so requests during
  // a load or in FINISH are dropped rather than queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (last_elem) state_nxt = DRAIN;
      // Leave once only the final write remains, so done follows it directly.
      DRAIN:   if (pipe_tail_only) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == FINISH);
    dram_rd_en = issue && in_bounds;
    dram_addr  = dram_rd_en ? rd_addr : '0;
  end

  // Row-major element counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      c_cnt <= '0;
    end else if (accept) begin
      r_cnt <= '0;
      c_cnt <= '0;
    end else if (issue) begin
      if (c_cnt == CNT_W'(TILE_SIZE - 1)) begin
        c_cnt <= '0;
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        c_cnt <= c_cnt + CNT_W'(1);
      end
    end
  end

  // Request snapshot, held for the whole load so input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_q  <= src_addr;
      dest_q <= dest_addr;
      n_q    <= matrix_size;
      row_q  <= tile_row;
      col_q  <= tile_col;
    end
  end

  rd_track_pipe #(
    .DEPTH      (DRAM_LATENCY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_track (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (issue),
    .in_pad    (~in_bounds),
    .in_addr   (wr_addr),
    .out_vld   (pipe_vld),
    .out_pad   (pipe_pad),
    .out_addr  (pipe_addr),
    .tail_only (pipe_tail_only)
  );

  // Write side: address/data forced to 0 whenever no write is happening.
  assign sram_we   = pipe_vld;
  assign sram_addr = pipe_vld ? pipe_addr : '0;
  assign sram_data = (pipe_vld && !pipe_pad) ? dram_rdata : '0;

endmodule

// File: tb/tb_tile_loader.sv
module tb_tile_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        startx = 1'b0;
  logic [15:0] src_addr = '0, dest_addr = '0, matrix_size = '0;
  logic [15:0] tile_row = '0, tile_col = '0;

  // Instance 0: latency 2, instance 1: latency 1, instance 2: latency 8.
  logic        busy_o [3], done_o [3], rd_o [3], we_o [3];
  logic [15:0] da_o [3], sa_o [3], sd_o [3], rdata [3];
  logic [15:0] dq0 [2], dq1 [1], dq2 [8];

  int vecs = 0, miss = 0;
  int cyc = 0, t0 = 0;
  int m_src, m_dest, m_n, m_tr, m_tc;
  int wr_cnt [3], rd_cnt [3], done_cnt [3], first_done [3], last_done [3];
  int first_we [3], last_we [3], first_rd [3];
  int addr_err [3], data_err [3], gap_err [3];
  int mon_rel, mon_k;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tile_loader #(.DRAM_LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .src_addr(src_addr),
    .dest_addr(dest_addr), .matrix_size(matrix_size), .tile_row(tile_row),
    .tile_col(tile_col), .busy(busy_o[0]), .done(done_o[0]),
    .dram_rd_en(rd_o[0]), .dram_addr(da_o[0]), .dram_rdata(rdata[0]),
    .sram_we(we_o[0]), .sram_addr(sa_o[0]), .sram_data(sd_o[0]));
  tile_loader #(.DRAM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startx), .src_addr(src_addr),
    .dest_addr(dest_addr), .matrix_size(matrix_size), .tile_row(tile_row),
    .tile_col(tile_col), .busy(busy_o[1]), .done(done_o[1]),
    .dram_rd_en(rd_o[1]), .dram_addr(da_o[1]), .dram_rdata(rdata[1]),
    .sram_we(we_o[1]), .sram_addr(sa_o[1]), .sram_data(sd_o[1]));
  tile_loader #(.DRAM_LATENCY(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(startx), .src_addr(src_addr),
    .dest_addr(dest_addr), .matrix_size(matrix_size), .tile_row(tile_row),
    .tile_col(tile_col), .busy(busy_o[2]), .done(done_o[2]),
    .dram_rd_en(rd_o[2]), .dram_addr(da_o[2]), .dram_rdata(rdata[2]),
    .sram_we(we_o[2]), .sram_addr(sa_o[2]), .sram_data(sd_o[2]));

  // DRAM models: return the read address as data; 0xDEAD when not read.
  always @(posedge clk) begin
    dq0[0] <= rd_o[0] ? da_o[0] : 16'hDEAD;
    dq0[1] <= dq0[0];
    dq1[0] <= rd_o[1] ? da_o[1] : 16'hDEAD;
    dq2[0] <= rd_o[2] ? da_o[2] : 16'hDEAD;
    for (int j = 1; j < 8; j++) dq2[j] <= dq2[j-1];
  end
  assign rdata[0] = dq0[1];
  assign rdata[1] = dq1[0];
  assign rdata[2] = dq2[7];

  // Expected data of tile element k for the current request.
  function automatic logic [15:0] model(int k);
    int r, c;
    r = k / 16;
    c = k % 16;
    if ((m_tr + r < m_n) && (m_tc + c < m_n))
      return 16'(m_src + (m_tr + r) * m_n + m_tc + c);
    return 16'h0000;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    mon_rel = cyc - t0;
    for (int i = 0; i < 3; i++) begin
      if (we_o[i]) begin
        mon_k = wr_cnt[i] % 256;
        if (sa_o[i] !== 16'(m_dest + mon_k)) addr_err[i]++;
        if (sd_o[i] !== model(mon_k)) data_err[i]++;
        if (mon_k != 0 && mon_rel != last_we[i] + 1) gap_err[i]++;
        if (wr_cnt[i] == 0) first_we[i] = mon_rel;
        last_we[i] = mon_rel;
        wr_cnt[i]++;
      end
      if (rd_o[i]) begin
        if (rd_cnt[i] == 0) first_rd[i] = mon_rel;
        rd_cnt[i]++;
      end
      if (done_o[i]) begin
        if (done_cnt[i] == 0) first_done[i] = mon_rel;
        last_done[i] = mon_rel;
        done_cnt[i]++;
      end
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < 3; i++) begin
      wr_cnt[i] = 0; rd_cnt[i] = 0; done_cnt[i] = 0;
      first_done[i] = -1; last_done[i] = -1; first_we[i] = -1;
      last_we[i] = -1; first_rd[i] = -1;
      addr_err[i] = 0; data_err[i] = 0; gap_err[i] = 0;
    end
  endtask

  task automatic set_params(input int s, input int d, input int n,
                            input int tr, input int tc);
    m_src = s; m_dest = d; m_n = n; m_tr = tr; m_tc = tc;
    src_addr = 16'(s); dest_addr = 16'(d); matrix_size = 16'(n);
    tile_row = 16'(tr); tile_col = 16'(tc);
  endtask

  // Presents start for one sampling edge (or leaves it high if hold) and
  // sets t0 so that the cycle after the sampling edge is relative cycle 1.
  task automatic launch(input bit main, input bit hold);
    @(posedge clk); #1;
    clear_mon();
    if (main) start0 = 1'b1; else startx = 1'b1;
    @(posedge clk); #1;
    t0 = cyc - 1;
    if (!hold) begin start0 = 1'b0; startx = 1'b0; end
  endtask

  task automatic wait_rel(input int n);
    int g = 0;
    while (cyc - t0 < n && g < 5000) begin @(posedge clk); #1; g++; end
  endtask

  task automatic wait_done(input int i, input int n);
    int g = 0;
    while (done_cnt[i] < n && g < 2000) begin @(posedge clk); #1; g++; end
    if (done_cnt[i] < n) begin
      vecs++; miss++;
      $display("FAIL timeout dut%0d: done count %0d, wanted %0d", i, done_cnt[i], n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (busy_o[0] !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b want 0", busy_o[0]); end
    vecs++; if (done_o[0] !== 1'b0) begin miss++; $display("FAIL rst_done: got %b want 0", done_o[0]); end
    vecs++; if (rd_o[0] !== 1'b0) begin miss++; $display("FAIL rst_rd_en: got %b want 0", rd_o[0]); end
    vecs++; if (we_o[0] !== 1'b0) begin miss++; $display("FAIL rst_we: got %b want 0", we_o[0]); end
    vecs++; if (da_o[0] !== 16'h0) begin miss++; $display("FAIL rst_dram_addr: got %h want 0", da_o[0]); end
    vecs++; if (sa_o[0] !== 16'h0) begin miss++; $display("FAIL rst_sram_addr: got %h want 0", sa_o[0]); end
    vecs++; if (sd_o[0] !== 16'h0) begin miss++; $display("FAIL rst_sram_data: got %h want 0", sd_o[0]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    set_params(16'h1000, 0, 64, 16, 32);
    launch(1'b1, 1'b0);
    wait_rel(5);
    // Inputs changing mid-load must not matter.
    src_addr = 16'h7777; dest_addr = 16'h0100; matrix_size = 16'd3;
    tile_row = 16'd0; tile_col = 16'd0;
    wait_rel(50);
    start0 = 1'b1;                 // ignored while busy
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done(0, 1);
    repeat (4) @(posedge clk);
    #1;
    vecs++; if (first_rd[0] !== 1) begin miss++; $display("FAIL basic_first_rd: got %0d want 1", first_rd[0]); end
    vecs++; if (rd_cnt[0] !== 256) begin miss++; $display("FAIL basic_rd_cnt: got %0d want 256", rd_cnt[0]); end
    vecs++; if (wr_cnt[0] !== 256) begin miss++; $display("FAIL basic_wr_cnt: got %0d want 256", wr_cnt[0]); end
    vecs++; if (first_we[0] !== 3) begin miss++; $display("FAIL basic_first_we: got %0d want 3", first_we[0]); end
    vecs++; if (addr_err[0] !== 0) begin miss++; $display("FAIL basic_sram_addr: got %0d bad want 0", addr_err[0]); end
    vecs++; if (data_err[0] !== 0) begin miss++; $display("FAIL basic_sram_data: got %0d bad want 0", data_err[0]); end
    vecs++; if (gap_err[0] !== 0) begin miss++; $display("FAIL basic_gaps: got %0d want 0", gap_err[0]); end
    vecs++; if (first_done[0] !== 259) begin miss++; $display("FAIL basic_done_cycle: got %0d want 259", first_done[0]); end
    vecs++; if (done_cnt[0] !== 1) begin miss++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt[0]); end
    vecs++; if (busy_o[0] !== 1'b0) begin miss++; $display("FAIL basic_idle_busy: got %b want 0", busy_o[0]); end
  endtask

  task automatic test_pad();
    set_params(16'h0400, 16'h0200, 20, 16, 16);
    launch(1'b1, 1'b0);
    wait_done(0, 1);
    vecs++; if (rd_cnt[0] !== 16) begin miss++; $display("FAIL pad_rd_cnt: got %0d want 16", rd_cnt[0]); end
    vecs++; if (wr_cnt[0] !== 256) begin miss++; $display("FAIL pad_wr_cnt: got %0d want 256", wr_cnt[0]); end
    vecs++; if (data_err[0] + addr_err[0] !== 0) begin miss++; $display("FAIL pad_data: got %0d bad want 0", data_err[0] + addr_err[0]); end
    vecs++; if (first_done[0] !== 259) begin miss++; $display("FAIL pad_done_cycle: got %0d want 259", first_done[0]); end
  endtask

  task automatic test_zero();
    set_params(16'h1000, 0, 0, 0, 0);
    launch(1'b1, 1'b0);
    wait_done(0, 1);
    vecs++; if (rd_cnt[0] !== 0) begin miss++; $display("FAIL zero_rd_cnt: got %0d want 0", rd_cnt[0]); end
    vecs++; if (wr_cnt[0] !== 256) begin miss++; $display("FAIL zero_wr_cnt: got %0d want 256", wr_cnt[0]); end
    vecs++; if (data_err[0] !== 0) begin miss++; $display("FAIL zero_data: got %0d bad want 0", data_err[0]); end
    vecs++; if (first_done[0] !== 259) begin miss++; $display("FAIL zero_done_cycle: got %0d want 259", first_done[0]); end
  endtask

  task automatic test_wrap();
    set_params(16'hF000, 16'hFFF8, 16'h1000, 16'h0020, 16'h0010);
    launch(1'b1, 1'b0);
    wait_done(0, 1);
    vecs++; if (rd_cnt[0] !== 256) begin miss++; $display("FAIL wrap_rd_cnt: got %0d want 256", rd_cnt[0]); end
    vecs++; if (data_err[0] !== 0) begin miss++; $display("FAIL wrap_data: got %0d bad want 0", data_err[0]); end
    vecs++; if (addr_err[0] !== 0) begin miss++; $display("FAIL wrap_sram_addr: got %0d bad want 0", addr_err[0]); end
  endtask

  task automatic test_start_held();
    set_params(16'h1000, 0, 64, 16, 32);
    launch(1'b1, 1'b1);
    wait_rel(261);
    vecs++; if (done_cnt[0] !== 1) begin miss++; $display("FAIL held_done_cnt: got %0d want 1", done_cnt[0]); end
    vecs++; if (first_done[0] !== 259) begin miss++; $display("FAIL held_done_cycle: got %0d want 259", first_done[0]); end
    vecs++; if (rd_o[0] !== 1'b1) begin miss++; $display("FAIL held_restart_rd: got %b want 1", rd_o[0]); end
    start0 = 1'b0;
    wait_done(0, 2);
    vecs++; if (last_done[0] !== 519) begin miss++; $display("FAIL held_done2_cycle: got %0d want 519", last_done[0]); end
    vecs++; if (wr_cnt[0] !== 512) begin miss++; $display("FAIL held_wr_cnt: got %0d want 512", wr_cnt[0]); end
    vecs++; if (data_err[0] !== 0) begin miss++; $display("FAIL held_data: got %0d bad want 0", data_err[0]); end
  endtask

  task automatic test_finish_start();
    set_params(16'h2000, 16'h0040, 64, 0, 0);
    launch(1'b1, 1'b0);
    wait_rel(259);
    vecs++; if (done_o[0] !== 1'b1) begin miss++; $display("FAIL fin_done: got %b want 1", done_o[0]); end
    start0 = 1'b1;                 // sampled in FINISH, must be dropped
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    vecs++; if (busy_o[0] !== 1'b0) begin miss++; $display("FAIL fin_start_busy: got %b want 0", busy_o[0]); end
    vecs++; if (rd_o[0] !== 1'b0) begin miss++; $display("FAIL fin_start_rd: got %b want 0", rd_o[0]); end
    vecs++; if (done_cnt[0] !== 1) begin miss++; $display("FAIL fin_done_cnt: got %0d want 1", done_cnt[0]); end
  endtask

  task automatic test_reset_mid();
    set_params(16'h1000, 0, 64, 16, 32);
    launch(1'b1, 1'b0);
    wait_rel(100);
    rst_n = 1'b0;
    #1;
    clear_mon();
    vecs++; if (we_o[0] !== 1'b0) begin miss++; $display("FAIL rstmid_we: got %b want 0", we_o[0]); end
    vecs++; if (busy_o[0] !== 1'b0) begin miss++; $display("FAIL rstmid_busy: got %b want 0", busy_o[0]); end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    vecs++; if (wr_cnt[0] !== 0) begin miss++; $display("FAIL rstmid_wr_cnt: got %0d want 0", wr_cnt[0]); end
    vecs++; if (done_cnt[0] !== 0) begin miss++; $display("FAIL rstmid_done_cnt: got %0d want 0", done_cnt[0]); end
    launch(1'b1, 1'b0);
    wait_done(0, 1);
    vecs++; if (wr_cnt[0] !== 256) begin miss++; $display("FAIL rstmid_reload_wr: got %0d want 256", wr_cnt[0]); end
    vecs++; if (first_done[0] !== 259) begin miss++; $display("FAIL rstmid_reload_done: got %0d want 259", first_done[0]); end
    vecs++; if (data_err[0] !== 0) begin miss++; $display("FAIL rstmid_reload_data: got %0d bad want 0", data_err[0]); end
  endtask

  task automatic test_latency();
    set_params(16'h1000, 16'h0300, 64, 16, 32);
    launch(1'b0, 1'b0);
    wait_done(1, 1);
    wait_done(2, 1);
    vecs++; if (first_done[1] !== 258) begin miss++; $display("FAIL lat1_done_cycle: got %0d want 258", first_done[1]); end
    vecs++; if (first_done[2] !== 265) begin miss++; $display("FAIL lat8_done_cycle: got %0d want 265", first_done[2]); end
    vecs++; if (first_we[1] !== 2) begin miss++; $display("FAIL lat1_first_we: got %0d want 2", first_we[1]); end
    vecs++; if (first_we[2] !== 9) begin miss++; $display("FAIL lat8_first_we: got %0d want 9", first_we[2]); end
    vecs++; if (wr_cnt[1] !== 256) begin miss++; $display("FAIL lat1_wr_cnt: got %0d want 256", wr_cnt[1]); end
    vecs++; if (wr_cnt[2] !== 256) begin miss++; $display("FAIL lat8_wr_cnt: got %0d want 256", wr_cnt[2]); end
    vecs++; if (gap_err[1] + gap_err[2] !== 0) begin miss++; $display("FAIL lat_gaps: got %0d want 0", gap_err[1] + gap_err[2]); end
    vecs++; if (data_err[1] + addr_err[1] !== 0) begin miss++; $display("FAIL lat1_data: got %0d bad want 0", data_err[1] + addr_err[1]); end
    vecs++; if (data_err[2] + addr_err[2] !== 0) begin miss++; $display("FAIL lat8_data: got %0d bad want 0", data_err[2] + addr_err[2]); end
    vecs++; if (done_cnt[0] !== 0) begin miss++; $display("FAIL lat_main_idle: got %0d want 0", done_cnt[0]); end
  endtask

  initial begin
    clear_mon();
    m_src = 0; m_dest = 0; m_n = 0; m_tr = 0; m_tc = 0;
    test_reset();
    test_basic();
    test_pad();
    test_zero();
    test_wrap();
    test_start_held();
    test_finish_start();
    test_reset_mid();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
